ramb_nibble_serializer: RTL and testbench
=========================================

Name: ramb_nibble_serializer

Overview:
- Reader-side companion for the dual-width block RAM (1-bit write side, 4-bit read side).
- Fetches a programmed run of nibbles from the RAM's 4-bit synchronous read port and emits them as a 1-bit serial stream, LSB first, with a valid/ready handshake.
- Used to play back bit-serial data previously written through the 1-bit port, restoring original bit order (bit i of nibble n = bit address n*4+i).

Parameters:
- ADDR_W, 10, nibble address width (1024 nibbles).
- NIB_W, 4, read-port data width; bits emitted per RAM word.

Ports:
- CLKA  in  1  clock; all logic on rising edge.
- RSTB  in  1  reset, synchronous, active-high.
- START  in  1  one-cycle request; sampled only in IDLE.
- START_ADDR  in  ADDR_W  first nibble address.
- LENGTH  in  ADDR_W+1  nibble count, 0..1024.
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  one-cycle completion pulse.
- RAM_EN  out  1  read enable to the RAM 4-bit port.
- RAM_ADDR  out  ADDR_W  read address.
- RAM_DO  in  NIB_W  RAM read data, valid the cycle after RAM_EN.
- BIT_OUT  out  1  serial data.
- BIT_VALID  out  1  BIT_OUT valid.
- BIT_READY  in  1  sink accepts the bit when VALID&READY.
- BIT_LAST  out  1  marks the final bit of the run.

Behaviour:
- Reset, synchronous on RSTB: BUSY, DONE, RAM_EN, BIT_VALID, BIT_LAST, BIT_OUT = 0; RAM_ADDR = 0; all counters, flags and registers cleared; state IDLE.
- Reset mid-run aborts immediately. Any in-flight RAM_DO is discarded. DONE is not pulsed.
- States: IDLE, RUN, FIN.
- IDLE, START=1, LENGTH>0: latch START_ADDR into the address counter and LENGTH into rd_left and bits_total counters; go to RUN.
- IDLE, START=1, LENGTH=0: go to FIN; no RAM read.
- START outside IDLE is ignored.
- Internal storage:
  - shift register SH (NIB_W bits) with count sh_cnt (0..NIB_W);
  - prefetch register NXT with flag nxt_v;
  - flag rd_pend (read in flight).
- Read issue (RUN): RAM_EN=1 in any cycle where rd_left>0 and !nxt_v and !rd_pend. That cycle RAM_ADDR = current address. On the edge: address += 1 mod 2^ADDR_W (1023 wraps to 0), rd_left -= 1, rd_pend = 1.
- RAM_EN=0 in every other cycle. RAM_ADDR holds its last value.
- Data capture (rd_pend=1):
  - if SH is empty or its last bit is consumed this cycle, RAM_DO loads SH (sh_cnt=NIB_W);
  - otherwise RAM_DO loads NXT (nxt_v=1).
  - rd_pend clears.
  - NXT can never be overwritten while valid; this is guaranteed by the issue rule.
- SH refill from NXT: when SH empties (or its last bit is consumed) and nxt_v=1, NXT loads SH and nxt_v clears.
- Output:
  - BIT_VALID = (sh_cnt>0); BIT_OUT = SH[0].
  - On VALID&READY: SH shifts right, sh_cnt -= 1, bits_total decrements.
  - With VALID high and READY low, BIT_OUT and BIT_LAST hold stable.
- BIT_LAST = BIT_VALID and this is the final bit of the run (LENGTH*NIB_W-th bit).
- Latency, START in cycle 0:
  - cycle 1: RAM_EN=1, RAM_ADDR=START_ADDR;
  - cycle 2: RAM_DO captured into SH;
  - cycle 3: first BIT_VALID.
- Throughput: with BIT_READY held high, exactly one bit per cycle, no bubbles between nibbles (second read issued in cycle 3, lands in NXT in cycle 4).
- Completion: after the handshake of the BIT_LAST bit, go to FIN. FIN pulses DONE=1 for one cycle, BUSY=0 in that cycle, then returns to IDLE. The next START is accepted the cycle after DONE.
- The block issues exactly LENGTH reads per run, never more (no over-fetch past the run).

Test Plan:
- Preload mem[5]=4'hA; START, START_ADDR=5, LENGTH=1, READY=1 -> VALID in cycles 3..6, BIT_OUT=0,1,0,1; BIT_LAST in cycle 6 only; DONE in cycle 7; exactly one RAM_EN.
- mem[0..2]=4'h1,4'hF,4'h6, LENGTH=3, READY=1 -> 12 consecutive VALID cycles, bits 1000 1111 0110, RAM_EN in cycles 1, 3, 7 only.
- Same run with READY toggling 1,0,0,1,... -> identical 12-bit sequence; BIT_OUT stable while stalled; no RAM_EN while nxt_v=1.
- START_ADDR=1023, LENGTH=2 -> RAM_ADDR 1023 then 0; bits of mem[1023] then mem[0].
- LENGTH=0 -> no RAM_EN, no VALID, DONE in cycle 1.
- RSTB asserted mid-run, after 5 bits -> next cycle all outputs 0, state IDLE, no DONE. A new START gives fresh latency-3 behaviour. A START issued while BUSY is ignored.

Source files
------------

// File: rtl/ramb_nibble_serializer.sv
// Reads a run of nibbles from the 4-bit port of the dual-width block RAM and
// plays them back as an LSB-first serial stream with a valid/ready handshake.
module ramb_nibble_serializer #(
    parameter int ADDR_W = 10,
    parameter int NIB_W  = 4
) (
    input  logic              CLKA,
    input  logic              RSTB,
    input  logic              START,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic [ADDR_W:0]   LENGTH,
    output logic              BUSY,
    output logic              DONE,
    output logic              RAM_EN,
    output logic [ADDR_W-1:0] RAM_ADDR,
    input  logic [NIB_W-1:0]  RAM_DO,
    output logic              BIT_OUT,
    output logic              BIT_VALID,
    input  logic              BIT_READY,
    output logic              BIT_LAST
);

    localparam int CW = $clog2(NIB_W + 1);
    localparam int BW = ADDR_W + 1 + $clog2(NIB_W);
    localparam logic [CW-1:0] SH_FULL = CW'(NIB_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t              state_r,      state_s;
    logic [ADDR_W-1:0]   addr_r,       addr_s;
    logic [ADDR_W:0]     rd_left_r,    rd_left_s;
    logic [BW-1:0]       bits_total_r, bits_total_s;
    logic [NIB_W-1:0]    sh_r,         sh_s;
    logic [CW-1:0]       sh_cnt_r,     sh_cnt_s;
    logic [NIB_W-1:0]    nxt_r,        nxt_s;
    logic                nxt_v_r,      nxt_v_s;
    logic                rd_pend_r,    rd_pend_s;
    logic                busy_r,       busy_s;
    logic                done_r,       done_s;
    logic                ram_en_r,     ram_en_s;
    logic [ADDR_W-1:0]   ram_addr_r,   ram_addr_s;
    logic                bit_out_r,    bit_out_s;
    logic                bit_valid_r,  bit_valid_s;
    logic                bit_last_r,   bit_last_s;
    logic                consume_s;
    logic                sh_empty_s;

    // Next-state logic; outputs are predicted from next state so they can be registered.
    always_comb begin
        state_s      = state_r;
        addr_s       = addr_r;
        rd_left_s    = rd_left_r;
        bits_total_s = bits_total_r;
        sh_s         = sh_r;
        sh_cnt_s     = sh_cnt_r;
        nxt_s        = nxt_r;
        nxt_v_s      = nxt_v_r;
        rd_pend_s    = rd_pend_r;

        consume_s  = (sh_cnt_r != {CW{1'b0}}) && BIT_READY;
        sh_empty_s = (sh_cnt_r == {CW{1'b0}}) || (consume_s && (sh_cnt_r == CW'(1)));

        if (consume_s) begin
            sh_s         = sh_r >> 1;
            sh_cnt_s     = sh_cnt_r - CW'(1);
            bits_total_s = bits_total_r - BW'(1);
        end else begin
            sh_s         = sh_r;
        end

        // The issue rule keeps rd_pend and nxt_v from ever being set together.
        if (rd_pend_r) begin
            rd_pend_s = 1'b0;
            if (sh_empty_s) begin
                sh_s     = RAM_DO;
                sh_cnt_s = SH_FULL;
            end else begin
                nxt_s    = RAM_DO;
                nxt_v_s  = 1'b1;
            end
        end else if (nxt_v_r && sh_empty_s) begin
            sh_s     = nxt_r;
            sh_cnt_s = SH_FULL;
            nxt_v_s  = 1'b0;
        end else begin
            rd_pend_s = 1'b0;
        end

        if (ram_en_r) begin
            addr_s    = addr_r + ADDR_W'(1);
            rd_left_s = rd_left_r - (ADDR_W + 1)'(1);
            rd_pend_s = 1'b1;
        end else begin
            addr_s    = addr_s;
        end

        case (state_r)
            IDLE: begin
                if (START) begin
                    if (LENGTH != {(ADDR_W + 1){1'b0}}) begin
                        state_s      = RUN;
                        addr_s       = START_ADDR;
                        rd_left_s    = LENGTH;
                        bits_total_s = BW'(LENGTH) * BW'(NIB_W);
                    end else begin
                        state_s      = FIN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (consume_s && (bits_total_r == BW'(1))) begin
                    state_s = FIN;
                end else begin
                    state_s = RUN;
                end
            end
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase

        ram_en_s    = (state_s == RUN) && (rd_left_s != {(ADDR_W + 1){1'b0}}) &&
                      !nxt_v_s && !rd_pend_s;
        ram_addr_s  = ram_en_s ? addr_s : ram_addr_r;
        bit_valid_s = (sh_cnt_s != {CW{1'b0}});
        bit_out_s   = sh_s[0];
        bit_last_s  = bit_valid_s && (bits_total_s == BW'(1));
        busy_s      = (state_s == RUN);
        done_s      = (state_s == FIN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLKA) begin
        if (RSTB) begin
            state_r      <= IDLE;
            addr_r       <= {ADDR_W{1'b0}};
            rd_left_r    <= {(ADDR_W + 1){1'b0}};
            bits_total_r <= {BW{1'b0}};
            sh_r         <= {NIB_W{1'b0}};
            sh_cnt_r     <= {CW{1'b0}};
            nxt_r        <= {NIB_W{1'b0}};
            nxt_v_r      <= 1'b0;
            rd_pend_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            ram_en_r     <= 1'b0;
            ram_addr_r   <= {ADDR_W{1'b0}};
            bit_out_r    <= 1'b0;
            bit_valid_r  <= 1'b0;
            bit_last_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            addr_r       <= addr_s;
            rd_left_r    <= rd_left_s;
            bits_total_r <= bits_total_s;
            sh_r         <= sh_s;
            sh_cnt_r     <= sh_cnt_s;
            nxt_r        <= nxt_s;
            nxt_v_r      <= nxt_v_s;
            rd_pend_r    <= rd_pend_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            ram_en_r     <= ram_en_s;
            ram_addr_r   <= ram_addr_s;
            bit_out_r    <= bit_out_s;
            bit_valid_r  <= bit_valid_s;
            bit_last_r   <= bit_last_s;
        end
    end

    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign RAM_EN    = ram_en_r;
    assign RAM_ADDR  = ram_addr_r;
    assign BIT_OUT   = bit_out_r;
    assign BIT_VALID = bit_valid_r;
    assign BIT_LAST  = bit_last_r;

endmodule

// File: tb/tb_ramb_nibble_serializer.sv
// Directed bench for ramb_nibble_serializer: behavioural RAM plus a bit scoreboard.
module tb_ramb_nibble_serializer;

    logic        CLKA = 1'b0;
    logic        RSTB;
    logic        START;
    logic [9:0]  START_ADDR;
    logic [10:0] LENGTH;
    logic        BUSY, DONE, RAM_EN, BIT_OUT, BIT_VALID, BIT_LAST;
    logic [9:0]  RAM_ADDR;
    logic [3:0]  RAM_DO;
    logic        BIT_READY;

    logic [3:0]  mem [0:1023];
    logic        sb [$];
    int          tests = 0;
    int          fails = 0;

    always #5 CLKA = ~CLKA;

    // Synchronous read port of the RAM: data one cycle after the enable.
    always @(posedge CLKA) begin
        if (RAM_EN) RAM_DO <= mem[RAM_ADDR];
    end

    ramb_nibble_serializer #(.ADDR_W(10), .NIB_W(4)) dut (
        .CLKA(CLKA), .RSTB(RSTB), .START(START), .START_ADDR(START_ADDR),
        .LENGTH(LENGTH), .BUSY(BUSY), .DONE(DONE), .RAM_EN(RAM_EN),
        .RAM_ADDR(RAM_ADDR), .RAM_DO(RAM_DO), .BIT_OUT(BIT_OUT),
        .BIT_VALID(BIT_VALID), .BIT_READY(BIT_READY), .BIT_LAST(BIT_LAST)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int k);
        if (mode == 0) return 1'b1;
        return ((k - 1) % 3) == 0;
    endfunction

    // One run: START in cycle 0, sample at negedge of each following cycle.
    task automatic run(input int saddr, input int len, input int mode, input int exp_done,
                       input int exp_first, input bit chk_en, input int spur);
        int k, nen, first_v, done_c;
        int en_cyc [3];
        logic prev_stall, prev_out, prev_last, e;
        logic [3:0] w;
        sb.delete();
        for (int n = 0; n < len; n++) begin
            w = mem[(saddr + n) % 1024];
            for (int i = 0; i < 4; i++) sb.push_back(w[i]);
        end
        en_cyc = '{-1, -1, -1};
        nen = 0; first_v = -1; done_c = -1; prev_stall = 1'b0; prev_out = 1'b0; prev_last = 1'b0;
        @(posedge CLKA); #1;
        START = 1'b1; START_ADDR = 10'(saddr); LENGTH = 11'(len); BIT_READY = rdy(mode, 0);
        @(posedge CLKA); #1;
        START = 1'b0; k = 1; BIT_READY = rdy(mode, 1);
        while (done_c < 0 && k < 200) begin
            @(negedge CLKA);
            if (k == 1 && len > 0) check("busy_cycle1", 32'(BUSY), 32'd1);
            if (RAM_EN) begin
                check("ram_addr", 32'(RAM_ADDR), 32'((saddr + nen) % 1024));
                if (nen < 3) en_cyc[nen] = k;
                nen++;
            end
            if (prev_stall && BIT_VALID) begin
                check("stall_out", 32'(BIT_OUT), 32'(prev_out));
                check("stall_last", 32'(BIT_LAST), 32'(prev_last));
            end
            if (BIT_VALID && first_v < 0) first_v = k;
            if (BIT_VALID && BIT_READY) begin
                if (sb.size() == 0) begin
                    check("extra_bit", 32'(BIT_VALID), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("bit", 32'(BIT_OUT), 32'(e));
                    check("bit_last", 32'(BIT_LAST), 32'(sb.size() == 0));
                end
            end
            prev_stall = BIT_VALID && !BIT_READY;
            prev_out = BIT_OUT;
            prev_last = BIT_LAST;
            if (DONE) begin
                done_c = k;
                check("busy_at_done", 32'(BUSY), 32'd0);
            end
            @(posedge CLKA); #1;
            k++;
            BIT_READY = rdy(mode, k);
            if (k == spur) begin
                START = 1'b1; START_ADDR = 10'd700; LENGTH = 11'd7;
            end else begin
                START = 1'b0;
            end
        end
        START = 1'b0;
        if (exp_done >= 0) check("done_cycle", 32'(done_c), 32'(exp_done));
        else check("done_seen", 32'(done_c >= 0), 32'd1);
        check("first_valid", 32'(first_v), 32'(exp_first));
        check("ram_en_count", 32'(nen), 32'(len));
        check("bits_left", 32'(sb.size()), 32'd0);
        if (chk_en) begin
            check("en_cycle0", 32'(en_cyc[0]), 32'd1);
            check("en_cycle1", 32'(en_cyc[1]), 32'd3);
            check("en_cycle2", 32'(en_cyc[2]), 32'd7);
        end
    endtask

    initial begin
        int hs;
        for (int i = 0; i < 1024; i++) mem[i] = 4'(i * 7 + 3);
        mem[5] = 4'hA; mem[0] = 4'h1; mem[1] = 4'hF; mem[2] = 4'h6; mem[1023] = 4'hC;
        RSTB = 1'b1; START = 1'b0; START_ADDR = 10'd0; LENGTH = 11'd0; BIT_READY = 1'b1;
        RAM_DO = 4'h0;
        repeat (2) @(posedge CLKA);
        @(negedge CLKA);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_ram_en", 32'(RAM_EN), 32'd0);
        check("rst_valid", 32'(BIT_VALID), 32'd0);
        check("rst_ram_addr", 32'(RAM_ADDR), 32'd0);
        RSTB = 1'b0;

        run(5, 1, 0, 7, 3, 1'b0, 0);
        run(0, 3, 0, 15, 3, 1'b1, 0);
        run(0, 3, 1, -1, 3, 1'b0, 0);
        run(1023, 2, 0, 11, 3, 1'b0, 0);
        run(0, 0, 0, 1, -1, 1'b0, 0);

        // Abort after five bits with a mid-run reset.
        @(posedge CLKA); #1;
        START = 1'b1; START_ADDR = 10'd100; LENGTH = 11'd3; BIT_READY = 1'b1;
        @(posedge CLKA); #1;
        START = 1'b0; hs = 0;
        for (int c = 0; c < 40 && hs < 5; c++) begin
            @(negedge CLKA);
            if (BIT_VALID && BIT_READY) hs++;
            if (hs < 5) begin
                @(posedge CLKA); #1;
            end
        end
        check("abort_handshakes", 32'(hs), 32'd5);
        @(posedge CLKA); #1;
        RSTB = 1'b1;
        @(posedge CLKA); #1;
        RSTB = 1'b0;
        @(negedge CLKA);
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_done", 32'(DONE), 32'd0);
        check("abort_ram_en", 32'(RAM_EN), 32'd0);
        check("abort_valid", 32'(BIT_VALID), 32'd0);
        check("abort_last", 32'(BIT_LAST), 32'd0);
        check("abort_out", 32'(BIT_OUT), 32'd0);
        check("abort_ram_addr", 32'(RAM_ADDR), 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge CLKA);
            check("abort_no_done", 32'(DONE), 32'd0);
            check("abort_idle_en", 32'(RAM_EN), 32'd0);
        end

        // Fresh run after the abort, with a START issued while busy.
        run(2, 2, 0, 11, 3, 1'b0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
